// File: rtl/axi_llc_sram_arb.sv
// axi_llc_sram_arb: round-robin share of one SRAM macro with read routing, scrub scheduling and ECC error counters
module axi_llc_sram_arb #(
   parameter int NumPorts     = 2,
   parameter int AddrWidth    = 10,
   parameter int DataWidth    = 128,
   parameter int BeWidth      = DataWidth / 8,
   parameter int RspLatency   = 1,
   parameter int ScrubPeriod  = 1024,
   parameter int ScrubMaxWait = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumPorts-1:0]           req_i,
   input  logic [NumPorts-1:0]           we_i,
   input  logic [NumPorts*AddrWidth-1:0] addr_i,
   input  logic [NumPorts*DataWidth-1:0] wdata_i,
   input  logic [NumPorts*BeWidth-1:0]   be_i,
   output logic [NumPorts-1:0]           gnt_o,
   output logic [NumPorts-1:0]           rvalid_o,
   output logic [DataWidth-1:0]          rdata_o,
   output logic                          sram_req_o,
   output logic                          sram_we_o,
   output logic [AddrWidth-1:0]          sram_addr_o,
   output logic [DataWidth-1:0]          sram_wdata_o,
   output logic [BeWidth-1:0]            sram_be_o,
   input  logic                          sram_gnt_i,
   input  logic [DataWidth-1:0]          sram_rdata_i,
   output logic                          scrub_trigger_o,
   input  logic                          single_error_i,
   input  logic                          multi_error_i,
   input  logic                          err_clear_i,
   output logic [15:0]                   single_err_cnt_o,
   output logic [15:0]                   multi_err_cnt_o
);
   localparam int PtrW  = $clog2(NumPorts);
   localparam int CntW  = ScrubPeriod > 1 ? $clog2(ScrubPeriod) : 1;
   localparam int WaitW = $clog2(ScrubMaxWait + 2);
   localparam logic [CntW-1:0]  CntMax   = CntW'(ScrubPeriod > 0 ? ScrubPeriod - 1 : 0);
   localparam logic [WaitW-1:0] WaitMax  = WaitW'(ScrubMaxWait);
   localparam logic [PtrW-1:0]  LastPort = PtrW'(NumPorts - 1);
   logic [PtrW-1:0]  ptr_q, win;
   logic [CntW-1:0]  scrub_cnt_q;
   logic [WaitW-1:0] wait_q;
   logic             pend_q, mask, wrap, hs;
   logic [RspLatency-1:0] vld_q;
   logic [PtrW-1:0]  idx_q [RspLatency];
   // descending scan so the lowest offset from the pointer wins
   always_comb begin
      win = ptr_q;
      for (int k = NumPorts - 1; k >= 0; k--)
         if (req_i[(int'(ptr_q) + k) % NumPorts]) win = PtrW'((int'(ptr_q) + k) % NumPorts);
   end
   assign mask            = pend_q && wait_q == WaitMax;
   assign sram_req_o      = |req_i & ~mask;
   assign hs              = sram_req_o & sram_gnt_i;
   assign scrub_trigger_o = pend_q & (~|req_i | mask);
   assign wrap            = (ScrubPeriod != 0) && scrub_cnt_q == CntMax;
   assign sram_we_o       = we_i[win];
   assign sram_addr_o     = addr_i[win*AddrWidth +: AddrWidth];
   assign sram_wdata_o    = wdata_i[win*DataWidth +: DataWidth];
   assign sram_be_o       = be_i[win*BeWidth +: BeWidth];
   assign rdata_o         = sram_rdata_i;
   always_comb begin
      gnt_o      = '0;
      gnt_o[win] = hs;
   end
   always_comb begin
      rvalid_o                      = '0;
      rvalid_o[idx_q[RspLatency-1]] = vld_q[RspLatency-1];
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q            <= '0;
         vld_q            <= '0;
         scrub_cnt_q      <= '0;
         wait_q           <= '0;
         pend_q           <= 1'b0;
         single_err_cnt_o <= '0;
         multi_err_cnt_o  <= '0;
         for (int i = 0; i < RspLatency; i++) idx_q[i] <= '0;
      end else begin
         if (hs) ptr_q <= win == LastPort ? '0 : win + 1'b1;
         vld_q[0] <= hs & ~sram_we_o;
         idx_q[0] <= win;
         for (int i = 1; i < RspLatency; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
         scrub_cnt_q      <= wrap ? '0 : scrub_cnt_q + 1'b1;
         pend_q           <= ~scrub_trigger_o & (pend_q | wrap);
         wait_q           <= pend_q & ~scrub_trigger_o ? wait_q + 1'b1 : '0;
         single_err_cnt_o <= err_clear_i ? '0 : single_err_cnt_o + 16'(single_error_i & ~&single_err_cnt_o);
         multi_err_cnt_o  <= err_clear_i ? '0 : multi_err_cnt_o + 16'(multi_error_i & ~&multi_err_cnt_o);
      end
   end
endmodule
